rvc_fetch_aligner: RTL and testbench

//  Instruction-fetch front end that feeds the RVC decoder. Fetches aligned 32-bit words from

---
 rtl/rvc_fetch_aligner_pkg.sv | 19 +
 rtl/rvc_fetch_aligner_if.sv | 30 +++
 rtl/rvc_hw_queue.sv | 60 ++++++
 rtl/rvc_fetch_aligner.sv | 91 +++++++++
 tb/tb_rvc_fetch_aligner.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvc_fetch_aligner_pkg.sv
// Shared types for the RVC fetch path: halfword type, fetch FSM states and the
// compressed-instruction test used by the aligner.
package RVC_Inst_Pkg;

   typedef logic [15:0] halfword_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_e;

   localparam int unsigned QDEPTH = 4;

   function automatic logic IsRVC(halfword_t hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/rvc_fetch_aligner_if.sv
// Fetch-aligner bus bundle: redirect, instruction-memory request/response and decode-side
// instruction handshake; master is the aligner, slave is the surrounding memory/decoder.
interface rvc_fetch_aligner_if;

   logic        flush;
   logic [31:0] flush_pc;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;

   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic        inst_is_rvc;
   logic [31:0] inst_pc;

   modport master (
      input  flush, flush_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
      output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_is_rvc, inst_pc
   );

   modport slave (
      output flush, flush_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
      input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_is_rvc, inst_pc
   );

endinterface

// File: rtl/rvc_hw_queue.sv
// 4-entry halfword shift queue; pops 0..2 from the head and appends 0..2 in the same cycle,
// head visible the cycle after a push. Caller guarantees room, so it never backpressures.
module rvc_hw_queue
   import RVC_Inst_Pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic [1:0] push_cnt_i,
   input  halfword_t  push_hw0_i,
   input  halfword_t  push_hw1_i,
   input  logic [1:0] pop_cnt_i,
   output halfword_t  hw0_o,
   output halfword_t  hw1_o,
   output logic [2:0] count_o
);

   halfword_t  buf_q [QDEPTH];
   halfword_t  buf_d [QDEPTH];
   logic [2:0] count_q, count_d;
   logic [2:0] kept;
   logic [1:0] wr_idx;

   assign kept   = count_q - {1'b0, pop_cnt_i};
   assign wr_idx = kept[1:0];

   always_comb begin
      buf_d = buf_q;
      case (pop_cnt_i)
         2'd1: begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            buf_d[2] = buf_q[3];
         end
         2'd2: begin
            buf_d[0] = buf_q[2];
            buf_d[1] = buf_q[3];
         end
         default: ;
      endcase
      // New halfwords land right behind the survivors of this cycle's pop.
      if (push_cnt_i != 2'd0) buf_d[wr_idx] = push_hw0_i;
      if (push_cnt_i == 2'd2) buf_d[wr_idx + 2'd1] = push_hw1_i;
      count_d = clear_i ? 3'd0 : kept + {1'b0, push_cnt_i};
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= 3'd0;
      else     count_q <= count_d;
   end

   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign hw0_o   = buf_q[0];
   assign hw1_o   = buf_q[1];
   assign count_o = count_q;

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Word fetch -> halfword buffer -> 16/32-bit instruction with PC; instruction valid the cycle
// after its last halfword arrives. Holds data while inst_ready=0; requests only when 2+ free.
module rvc_fetch_aligner
   import RVC_Inst_Pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                 clk,
   input logic                 rst,
   rvc_fetch_aligner_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_addr_q, fetch_addr_d;
   logic [31:0]  head_pc_q, head_pc_d;
   logic         skip_low_q, skip_low_d;

   halfword_t    hw0, hw1;
   logic [2:0]   count;
   logic [1:0]   push_cnt, pop_cnt;
   logic         is_rvc, inst_vld, req_vld, req_fire, rsp_take;

   assign is_rvc   = IsRVC(hw0);
   assign inst_vld = !rst && ((count >= 3'd1 && is_rvc) || count >= 3'd2);
   assign req_vld  = !rst && (state_q == IDLE) && (count <= 3'd2);
   assign req_fire = req_vld && bus.mem_req_ready;
   assign rsp_take = (state_q == WAIT) && bus.mem_rsp_valid && !bus.flush;
   assign push_cnt = rsp_take ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
   assign pop_cnt  = (inst_vld && bus.inst_ready && !bus.flush) ? (is_rvc ? 2'd1 : 2'd2) : 2'd0;

   rvc_hw_queue u_queue (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (bus.flush),
      .push_cnt_i (push_cnt),
      .push_hw0_i (skip_low_q ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0]),
      .push_hw1_i (bus.mem_rsp_data[31:16]),
      .pop_cnt_i  (pop_cnt),
      .hw0_o      (hw0),
      .hw1_o      (hw1),
      .count_o    (count)
   );

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      skip_low_d   = skip_low_q;
      head_pc_d    = head_pc_q + {29'd0, pop_cnt, 1'b0};
      case (state_q)
         IDLE: if (req_fire) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
            state_d      = WAIT;
         end
         WAIT: if (bus.mem_rsp_valid) begin
            state_d    = IDLE;
            skip_low_d = 1'b0;
         end
         DROP: if (bus.mem_rsp_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush) begin
         fetch_addr_d = {bus.flush_pc[31:2], 2'b00};
         head_pc_d    = bus.flush_pc & ~32'd1;
         skip_low_d   = bus.flush_pc[1];
         // Any response still owed to the old stream must be swallowed before refetching.
         state_d      = (state_d == IDLE) ? IDLE : DROP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         fetch_addr_q <= {RESET_PC[31:2], 2'b00};
         head_pc_q    <= RESET_PC & ~32'd1;
         skip_low_q   <= RESET_PC[1];
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         head_pc_q    <= head_pc_d;
         skip_low_q   <= skip_low_d;
      end
   end

   assign bus.mem_req_valid = req_vld;
   assign bus.mem_req_addr  = fetch_addr_q;
   assign bus.inst_valid    = inst_vld;
   assign bus.inst_data     = is_rvc ? {16'h0000, hw0} : {hw1, hw0};
   assign bus.inst_is_rvc   = is_rvc;
   assign bus.inst_pc       = head_pc_q;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Randomised bench for rvc_fetch_aligner: the expected instruction stream is derived from a
// memory image and a program counter, independent of how the aligner buffers halfwords.
module tb_rvc_fetch_aligner;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rvc_fetch_aligner_if bus();

   rvc_fetch_aligner #(.RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] ovr [bit [31:0]];

   // stimulus knobs
   bit          rst_now, flush_now;
   logic [31:0] flush_pc_now;
   int          irdy_pct, mrdy_pct, lat_min, lat_max;

   // memory model
   bit          pending, stale, rsp_now;
   logic [31:0] paddr;
   int          lat_cnt, rsp_cnt, acc_cnt;
   logic [31:0] acc_addr_q[$];

   // reference program counter and handshake log
   logic [31:0] exp_pc;
   logic [31:0] hs_pc[$];
   logic [31:0] hs_data[$];
   logic [31:0] hs_rvc[$];
   int          hs_rsp[$];
   bit          prev_hold, after_rst;
   logic [31:0] prev_addr;
   int          noprog;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      logic [31:0] x;
      if (ovr.exists(a)) return ovr[a];
      x = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
      x = x ^ (x >> 15);
      x = x * 32'h85EB_CA6B;
      x = x ^ (x >> 13);
      return x;
   endfunction

   function automatic logic [15:0] hw_at(logic [31:0] pc);
      logic [31:0] w;
      w = mem_word({pc[31:2], 2'b00});
      return pc[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic clear_logs();
      acc_cnt = 0;
      rsp_cnt = 0;
      acc_addr_q.delete();
      hs_pc.delete();
      hs_data.delete();
      hs_rvc.delete();
      hs_rsp.delete();
   endtask

   task automatic step();
      logic [15:0] h0, h1;
      logic [31:0] e_data;
      logic        e_rvc;
      @(negedge clk);
      rst                = rst_now;
      bus.flush          = flush_now;
      bus.flush_pc       = flush_pc_now;
      bus.inst_ready     = ($urandom_range(99, 0) < irdy_pct);
      bus.mem_req_ready  = !pending && ($urandom_range(99, 0) < mrdy_pct);
      bus.mem_rsp_valid  = 1'b0;
      bus.mem_rsp_data   = $urandom;
      rsp_now            = 1'b0;
      if (pending) begin
         lat_cnt--;
         if (lat_cnt <= 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_word(paddr);
            pending           = 1'b0;
            rsp_now           = !stale;
            stale             = 1'b0;
         end
      end
      #1;
      if (rst) begin
         check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
         check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
         exp_pc    = RESET_PC & ~32'd1;
         if (pending) stale = 1'b1;
         prev_hold = 1'b0;
         after_rst = 1'b1;
         noprog    = 0;
      end else begin
         if (after_rst) begin
            check("post_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
            after_rst = 1'b0;
         end
         if (prev_hold) begin
            check("req_hold_valid", 32'(bus.mem_req_valid), 32'd1);
            check("req_hold_addr", bus.mem_req_addr, prev_addr);
         end
         if (pending && !stale) check("one_outstanding", 32'(bus.mem_req_valid), 32'd0);
         if (bus.mem_req_valid) check("req_align", 32'(bus.mem_req_addr[1:0]), 32'd0);
         if (bus.inst_valid) begin
            h0     = hw_at(exp_pc);
            h1     = hw_at(exp_pc + 32'd2);
            e_rvc  = (h0[1:0] != 2'b11);
            e_data = e_rvc ? {16'h0000, h0} : {h1, h0};
            check("inst_pc", bus.inst_pc, exp_pc);
            check("inst_data", bus.inst_data, e_data);
            check("inst_is_rvc", 32'(bus.inst_is_rvc), 32'(e_rvc));
            if (bus.inst_ready) begin
               hs_pc.push_back(bus.inst_pc);
               hs_data.push_back(bus.inst_data);
               hs_rvc.push_back(32'(bus.inst_is_rvc));
               hs_rsp.push_back(rsp_cnt);
               exp_pc = exp_pc + (e_rvc ? 32'd2 : 32'd4);
               noprog = 0;
            end
         end else if (bus.inst_ready) begin
            noprog++;
         end
         if (noprog > 60) begin
            check("progress_timeout", 32'(noprog), 32'd0);
            noprog = 0;
         end
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            pending = 1'b1;
            stale   = 1'b0;
            paddr   = bus.mem_req_addr;
            lat_cnt = int'($urandom_range(lat_max, lat_min));
            acc_cnt++;
            acc_addr_q.push_back(bus.mem_req_addr);
         end
         prev_hold = bus.mem_req_valid && !bus.mem_req_ready && !bus.flush;
         prev_addr = bus.mem_req_addr;
         if (bus.flush) exp_pc = bus.flush_pc & ~32'd1;
      end
      if (rsp_now) rsp_cnt++;
      flush_now = 1'b0;
   endtask

   task automatic do_reset(int n);
      rst_now = 1'b1;
      repeat (n) step();
      rst_now = 1'b0;
      clear_logs();
   endtask

   task automatic expect_hs(string nm, int idx, logic [31:0] pc, logic [31:0] data, bit rvc);
      if (hs_pc.size() > idx) begin
         check({nm, "_pc"}, hs_pc[idx], pc);
         check({nm, "_data"}, hs_data[idx], data);
         check({nm, "_rvc"}, hs_rvc[idx], 32'(rvc));
      end else begin
         check({nm, "_missing"}, 32'(hs_pc.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0; bus.flush_pc = '0; bus.inst_ready = 1'b0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
      rst_now = 1'b1; flush_now = 1'b0; flush_pc_now = '0;
      irdy_pct = 100; mrdy_pct = 100; lat_min = 1; lat_max = 1;
      pending = 1'b0; stale = 1'b0; exp_pc = RESET_PC; prev_hold = 1'b0; after_rst = 1'b0;
      prev_addr = '0; paddr = '0; lat_cnt = 0; noprog = 0;
      clear_logs();

      // two RVC instructions in one word
      ovr.delete(); ovr[32'h0] = 32'h4585_4501;
      do_reset(3);
      repeat (12) step();
      expect_hs("t1_i0", 0, 32'h0, 32'h0000_4501, 1'b1);
      expect_hs("t1_i1", 1, 32'h2, 32'h0000_4585, 1'b1);

      // 32-bit instruction straddling words 0 and 4
      ovr.delete(); ovr[32'h0] = 32'h0093_4501; ovr[32'h4] = 32'h4501_0100;
      lat_min = 2; lat_max = 2;
      do_reset(3);
      repeat (20) step();
      expect_hs("t2_i0", 0, 32'h0, 32'h0000_4501, 1'b1);
      expect_hs("t2_i1", 1, 32'h2, 32'h0100_0093, 1'b0);
      expect_hs("t2_i2", 2, 32'h6, 32'h0000_4501, 1'b1);
      if (hs_rsp.size() > 1) check("t2_after_2nd_rsp", 32'(hs_rsp[1] >= 2), 32'd1);

      // consumer stall fills the buffer and stops fetching
      ovr.delete(); ovr[32'h0] = 32'h4585_4501;
      lat_min = 1; lat_max = 1; irdy_pct = 0;
      do_reset(3);
      repeat (20) step();
      check("t3_accepts", 32'(acc_cnt), 32'd2);
      check("t3_req_valid", 32'(bus.mem_req_valid), 32'd0);
      check("t3_inst_pc", bus.inst_pc, 32'h0);
      check("t3_inst_data", bus.inst_data, 32'h0000_4501);
      irdy_pct = 100;
      repeat (10) step();

      // flush while a fetch is outstanding; the stale response must be dropped
      ovr.delete(); ovr[32'h100] = 32'h1234_4503;
      lat_min = 4; lat_max = 4;
      do_reset(3);
      for (int i = 0; i < 10 && acc_cnt == 0; i++) step();
      step();
      flush_now = 1'b1; flush_pc_now = 32'h0000_0102;
      step();
      clear_logs();
      lat_min = 1; lat_max = 2;
      repeat (15) step();
      if (acc_addr_q.size() > 0) check("t4_req_addr", acc_addr_q[0], 32'h100);
      else check("t4_req_missing", 32'(acc_addr_q.size()), 32'd1);
      expect_hs("t4_i0", 0, 32'h102, 32'h0000_1234, 1'b1);

      // request held while mem_req_ready is low
      ovr.delete();
      mrdy_pct = 0; lat_min = 1; lat_max = 1;
      do_reset(3);
      for (int i = 0; i < 6; i++) begin
         step();
         check("t5_req_valid", 32'(bus.mem_req_valid), 32'd1);
         check("t5_req_addr", bus.mem_req_addr, RESET_PC);
      end
      mrdy_pct = 100;
      step();
      check("t5_accepts", 32'(acc_cnt), 32'd1);
      repeat (8) step();

      // reset with a fetch outstanding; the late response must be ignored
      ovr.delete(); ovr[32'h0] = 32'h4501_4501; ovr[32'h4] = 32'h4585_4585;
      irdy_pct = 0; lat_min = 4; lat_max = 4;
      do_reset(3);
      for (int i = 0; i < 30 && acc_cnt < 2; i++) step();
      rst_now = 1'b1;
      step();
      rst_now = 1'b0;
      clear_logs();
      irdy_pct = 100; lat_min = 1; lat_max = 1;
      step();
      check("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
      repeat (20) step();
      if (acc_addr_q.size() > 0) check("t6_req_addr", acc_addr_q[0], RESET_PC);
      else check("t6_req_missing", 32'(acc_addr_q.size()), 32'd1);
      expect_hs("t6_i0", 0, 32'h0, 32'h0000_4501, 1'b1);

      // randomised traffic with flushes, resets and address wrap
      ovr.delete();
      lat_min = 1; lat_max = 3; mrdy_pct = 75; irdy_pct = 70;
      do_reset(2);
      for (int i = 0; i < 5000; i++) begin
         if (i % 200 == 0) irdy_pct = (i % 800 == 400) ? 0 : int'($urandom_range(100, 20));
         if ($urandom_range(39, 0) == 0) begin
            flush_now    = 1'b1;
            flush_pc_now = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF8 | ($urandom & 32'h7))
                                                       : ($urandom & 32'h0000_0FFF);
         end
         if ($urandom_range(499, 0) == 0) begin
            rst_now = 1'b1;
            step();
            rst_now = 1'b0;
         end else begin
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
